// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// in_ready is a flop, so a downstream stall reaches upstream one cycle late; the skid entry absorbs that beat.
module pipe_stage_skid #(
  parameter int          DATA_W   = 64,
  parameter int          PC_W     = 32,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam logic [PC_W-1:0] EXC_PC_W   = PC_W'(EXC_PC);
  localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);

  // Encodings equal the live-entry count, so occupancy is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic                in_ready_q,  in_ready_d;
  logic [PC_W-1:0]     main_pc_q,   main_pc_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [PC_W-1:0]     skid_pc_q,   skid_pc_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;

  logic accept;
  logic deliver;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign out_pc    = main_pc_q;
  assign out_data  = main_data_q;
  assign occupancy = state_q;

  assign accept  = in_valid & in_ready_q;
  assign deliver = out_valid & out_ready;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_data_d = main_data_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;

    if (req || flush) begin
      // req outranks flush; any beat on in_* this cycle is dropped.
      state_d     = EMPTY;
      main_pc_d   = req ? EXC_PC_W : RESET_PC_W;
      main_data_d = '0;
      skid_pc_d   = '0;
      skid_data_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            main_pc_d   = in_pc;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = TWO;
            skid_pc_d   = in_pc;
            skid_data_d = in_data;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (deliver) begin
            state_d     = ONE;
            main_pc_d   = skid_pc_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign in_ready_d = (state_d != TWO);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: both entries are reset because the cleared payload/PC values are architecturally visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_pc_q   <= RESET_PC_W;
      main_data_q <= '0;
      skid_pc_q   <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_pc_q   <= main_pc_d;
      main_data_q <= main_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks for pipe_stage_skid: handshake, skid, req/flush, async reset, ordering.
module tb_pipe_stage_skid;

  localparam int DATA_W = 64;
  localparam int PC_W   = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t sb[$];

  pipe_stage_skid #(
    .DATA_W  (DATA_W),
    .PC_W    (PC_W),
    .EXC_PC  (32'h0000_4180),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_pc    (in_pc),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc   (out_pc),
    .out_data (out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] data);
    in_valid = 1'b1;
    in_pc    = pc;
    in_data  = data;
  endtask

  initial begin
    int sent;
    int got;
    logic saved_ready;

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_occ",       64'(occupancy), 64'd0);
    check("rst_out_pc",    64'(out_pc),    64'd0);
    check("rst_out_data",  out_data,       64'd0);
    #5 reset = 1'b1;
    step();

    // Streaming at full rate: one-cycle latency, occupancy stays 1.
    out_ready = 1'b1;
    send(32'h3000, 64'hA0);
    step();
    check("str0_pc",   64'(out_pc), 64'h3000);
    check("str0_data", out_data, 64'hA0);
    check("str0_occ",  64'(occupancy), 64'd1);
    send(32'h3004, 64'hA4);
    step();
    check("str1_pc",   64'(out_pc), 64'h3004);
    check("str1_rdy",  64'(in_ready), 64'd1);
    send(32'h3008, 64'hA8);
    step();
    check("str2_pc",   64'(out_pc), 64'h3008);
    check("str2_occ",  64'(occupancy), 64'd1);
    in_valid = 1'b0;
    step();
    check("drain_occ",  64'(occupancy), 64'd0);
    check("drain_keep", 64'(out_pc), 64'h3008);

    // Stall fills the skid entry.
    out_ready = 1'b0;
    send(32'h3000, 64'hB0);
    step();
    check("stall1_occ", 64'(occupancy), 64'd1);
    check("stall1_rdy", 64'(in_ready), 64'd1);
    send(32'h3004, 64'hB4);
    step();
    in_valid = 1'b0;
    check("stall2_occ", 64'(occupancy), 64'd2);
    check("stall2_rdy", 64'(in_ready), 64'd0);
    check("stall2_pc",  64'(out_pc), 64'h3000);
    out_ready = 1'b1;
    #1;
    check("comb_rdy", 64'(in_ready), 64'd0);
    step();
    check("unstall_pc",   64'(out_pc), 64'h3004);
    check("unstall_data", out_data, 64'hB4);
    check("unstall_occ",  64'(occupancy), 64'd1);
    check("unstall_rdy",  64'(in_ready), 64'd1);
    step();
    check("unstall_empty", 64'(occupancy), 64'd0);

    // req while TWO, with a beat presented.
    out_ready = 1'b0;
    send(32'h3010, 64'hC0);
    step();
    send(32'h3014, 64'hC4);
    step();
    check("req_pre_occ", 64'(occupancy), 64'd2);
    send(32'h9999, 64'hDEAD);
    req = 1'b1;
    step();
    req = 1'b0;
    in_valid = 1'b0;
    check("req_valid", 64'(out_valid), 64'd0);
    check("req_occ",   64'(occupancy), 64'd0);
    check("req_pc",    64'(out_pc), 64'h4180);
    check("req_data",  out_data, 64'd0);
    check("req_rdy",   64'(in_ready), 64'd1);
    out_ready = 1'b1;
    step();
    check("req_nobeat", 64'(out_valid), 64'd0);

    // req while ONE with an acceptable beat: the beat is dropped.
    out_ready = 1'b0;
    send(32'h3020, 64'hD0);
    step();
    send(32'h3024, 64'hD4);
    req = 1'b1;
    step();
    req = 1'b0;
    in_valid = 1'b0;
    check("req1_occ", 64'(occupancy), 64'd0);
    step();
    check("req1_drop", 64'(out_valid), 64'd0);

    // req and flush together: req wins. Then flush alone.
    send(32'h3030, 64'hE0);
    step();
    in_valid = 1'b0;
    check("rf_pre_occ", 64'(occupancy), 64'd1);
    req = 1'b1;
    flush = 1'b1;
    step();
    req = 1'b0;
    flush = 1'b0;
    check("rf_pc",    64'(out_pc), 64'h4180);
    check("rf_valid", 64'(out_valid), 64'd0);
    send(32'h3034, 64'hE4);
    step();
    in_valid = 1'b0;
    check("fl_pre_pc", 64'(out_pc), 64'h3034);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_pc",    64'(out_pc), 64'd0);
    check("fl_data",  out_data, 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-run with two live entries.
    send(32'h3040, 64'hF0);
    step();
    send(32'h3044, 64'hF4);
    step();
    in_valid = 1'b0;
    check("mr_pre_occ", 64'(occupancy), 64'd2);
    #3 reset = 1'b0;
    #1;
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_occ",   64'(occupancy), 64'd0);
    check("mr_rdy",   64'(in_ready), 64'd1);
    check("mr_pc",    64'(out_pc), 64'd0);
    check("mr_data",  out_data, 64'd0);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    step();
    check("mr_post_valid", 64'(out_valid), 64'd0);

    // Random valid/ready over 1000 beats against a FIFO scoreboard.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
      in_pc     = $urandom;
      in_data   = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      saved_ready = in_ready;
      out_ready = ~out_ready;
      #1;
      if (in_ready !== saved_ready) check("rnd_comb_rdy", 64'(in_ready), 64'(saved_ready));
      out_ready = ~out_ready;
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rnd_spurious", 64'(out_valid), 64'd0);
        end else begin
          check("rnd_pc",   64'(out_pc), 64'(sb[0].pc));
          check("rnd_data", out_data, sb[0].data);
          void'(sb.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back('{pc: in_pc, data: in_data});
        sent++;
      end
      step();
      check("rnd_occ", 64'(occupancy), 64'(sb.size()));
      check("rnd_rdy", 64'(in_ready), 64'(sb.size() < 2));
    end
    in_valid = 1'b0;
    check("rnd_count", 64'(got), 64'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
- Replaces fixed-field inter-stage registers: carries a PC plus an opaque payload bus of configurable width.
- Lets a downstream stall propagate upstream one cycle late without losing data.
- Supports bubble flush and exception/interrupt redirect (Req), which loads the exception-entry PC into the stage.

Parameters:
- DATA_W, 64: payload width in bits (packed control plus data fields of the stage).
- PC_W, 32: PC field width.
- EXC_PC, 32'h0000_4180: PC value loaded on req (truncated/zero-extended to PC_W).
- RESET_PC, 0: PC value after reset or flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  1  exception/interrupt redirect; highest synchronous priority.
- flush  input  1  squash stage contents (bubble).
- in_valid  input  1  upstream has a beat.
- in_ready  output  1  stage can accept a beat; registered.
- in_pc  input  PC_W  upstream PC.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  main entry holds a live beat.
- out_ready  input  1  downstream accepts this cycle.
- out_pc  output  PC_W  main entry PC.
- out_data  output  DATA_W  main entry payload.
- occupancy  output  2  live entries: 0, 1 or 2.

Behaviour:
- Storage: main entry (pc, data, valid) drives the out_* ports; skid entry (pc, data, valid) is internal.
- accept = in_valid & in_ready; deliver = out_valid & out_ready.
- States: EMPTY (neither entry valid), ONE (main valid), TWO (main and skid valid). occupancy = 0/1/2 respectively.
- in_ready = 1 in EMPTY and ONE, 0 in TWO. It is a register output and never combinationally depends on out_ready.
- Transitions, per clock edge:
  - EMPTY: accept -> ONE, main <= in. No accept -> hold.
  - ONE: accept & deliver -> ONE, main <= in. accept & !deliver -> TWO, skid <= in. deliver only -> EMPTY. Neither -> hold.
  - TWO: deliver -> ONE, main <= skid. No deliver -> hold. No accept is possible in TWO.
- Payload/PC of an empty main entry keep their last written values. Exceptions: after reset/flush they are RESET_PC/0; after req they are EXC_PC/0.
- Priority per edge: req > flush > normal update.
  - req: both entries invalid, state EMPTY, main pc <= EXC_PC, main data <= 0, skid cleared to 0. Beat presented on in_* that cycle is dropped, even if in_valid=1.
  - flush: same as req, but main pc <= RESET_PC.
  - req and flush together: req wins, so out_pc = EXC_PC.
- A beat delivered on the same edge as req/flush counts as delivered downstream; the stage still ends EMPTY.
- Reset (asynchronous, active-low): immediately out_valid=0, in_ready=1, occupancy=0, out_pc=RESET_PC, out_data=0, skid cleared.
  - Release is sampled at the next rising edge.
  - Reset mid-transfer discards all content.
- Latency: an accepted beat appears on out_* one cycle after acceptance when the stage is empty (or when ONE with deliver). From skid it appears one cycle after the deliver that frees main.
- Ordering is strictly FIFO. No beat is duplicated or lost except by req/flush/reset.
- in_ready drops in the cycle after the stage enters TWO and rises in the cycle after TWO->ONE.

Test Plan:
- Reset low mid-run with occupancy=2 -> out_valid=0, occupancy=0, in_ready=1, out_pc=0 asynchronously, before any clock edge.
- Stream in_valid=1, out_ready=1, pc 0x3000, 0x3004, 0x3008 -> out_pc follows one cycle later each cycle, occupancy stays 1, in_ready stays 1.
- Hold out_ready=0 while sending pc 0x3000 then 0x3004 -> occupancy=2, in_ready=0, out_pc=0x3000. Raise out_ready -> next cycle out_pc=0x3004, occupancy=1, in_ready=1.
- In TWO state assert req for one cycle with in_valid=1 -> next edge out_valid=0, occupancy=0, out_pc=0x0000_4180, out_data=0, input beat not seen later.
- Assert flush and req in the same cycle with occupancy=1 -> out_pc=0x0000_4180, out_valid=0. Assert flush alone -> out_pc=0, out_valid=0.
- Random valid/ready over 1000 beats with DATA_W=64 -> scoreboard shows identical in-order sequence, and in_ready never changes combinationally with out_ready.
